// File: rtl/acm_pkg.sv
// Shared types and widths for the ACM init sequencer: FSM states, ACM bus widths
// and the wait-counter width used for both the reset and write-strobe timing.
package acm_pkg;

  localparam int ACM_AW = 8;
  localparam int ACM_DW = 8;
  localparam int CNT_W  = 4;
  localparam int WCNT_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    ACMRST,
    FETCH,
    LATCH,
    WRITE,
    HOLD,
    NEXT
  } state_t;

endpackage

// File: rtl/acm_init_sequencer_if.sv
// Table, ACM and status signals of the init sequencer; master is the sequencer,
// slave is the surrounding table / ACM / processor side.
interface acm_init_sequencer_if;
  import acm_pkg::*;

  logic                START;
  logic [ACM_AW-1:0]   TBL_ADDR;
  logic [ACM_DW-1:0]   TBL_DATA;
  logic                TBL_DO;
  logic [ACM_AW-1:0]   ACMADDR;
  logic [ACM_DW-1:0]   ACMWDATA;
  logic                ACMWEN;
  logic                ACMRESETN;
  logic                BUSY;
  logic                DONE;
  logic [WCNT_W-1:0]   WR_COUNT;

  modport master (
    input  START, TBL_DATA, TBL_DO,
    output TBL_ADDR, ACMADDR, ACMWDATA, ACMWEN, ACMRESETN, BUSY, DONE, WR_COUNT
  );

  modport slave (
    output START, TBL_DATA, TBL_DO,
    input  TBL_ADDR, ACMADDR, ACMWDATA, ACMWEN, ACMRESETN, BUSY, DONE, WR_COUNT
  );

endinterface

// File: rtl/acm_wait_counter.sv
// Loadable down-counter; tc flags the last cycle of a loaded wait (count == 1).
// Shared by the ACM reset hold and the write-strobe stretch.
module acm_wait_counter
  import acm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(1));

endmodule

// File: rtl/acm_init_sequencer.sv
// Walks the ACM lookup table from START_ADDR to END_ADDR and writes every valid
// entry into the ACM port with a stretched write strobe. All outputs registered.
module acm_init_sequencer
  import acm_pkg::*;
#(
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 255,
  parameter int RST_CYCLES = 4,
  parameter int WR_CYCLES  = 3,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                 PCLK,
  input  logic                 NSYSRESET,
  acm_init_sequencer_if.master bus
);

  localparam logic [ACM_AW-1:0] START_A = ACM_AW'(START_ADDR);
  localparam logic [ACM_AW-1:0] END_A   = ACM_AW'(END_ADDR);
  localparam logic [CNT_W-1:0]  RST_LD  = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0]  WR_LD   = CNT_W'(WR_CYCLES);
  localparam logic [WCNT_W-1:0] WR_MAX  = WCNT_W'(256);

  state_t              state;
  logic [ACM_AW-1:0]   tbl_addr;
  logic [ACM_AW-1:0]   acm_addr;
  logic [ACM_DW-1:0]   acm_wdata;
  logic                acm_wen;
  logic                acm_resetn;
  logic                busy;
  logic                done;
  logic [WCNT_W-1:0]   wr_count;
  logic                pending;

  logic                launch;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                cnt_tc;

  assign launch   = (state == IDLE) && (bus.START || pending);
  assign cnt_load = launch || ((state == LATCH) && bus.TBL_DO);
  assign cnt_val  = (state == IDLE) ? RST_LD : WR_LD;

  acm_wait_counter u_wait (
    .clk      (PCLK),
    .rst_n    (NSYSRESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_ff @(posedge PCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state      <= IDLE;
      tbl_addr   <= START_A;
      acm_addr   <= '0;
      acm_wdata  <= '0;
      acm_wen    <= 1'b0;
      acm_resetn <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_count   <= '0;
      pending    <= AUTO_START;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state      <= ACMRST;
            busy       <= 1'b1;
            done       <= 1'b0;
            wr_count   <= '0;
            tbl_addr   <= START_A;
            acm_resetn <= 1'b0;
            pending    <= 1'b0;
          end
        end
        // Reset is released after RST_CYCLES low cycles; one more cycle lets the
        // ACM recover before the first table fetch.
        ACMRST: begin
          if (acm_resetn) begin
            state <= FETCH;
          end else if (cnt_tc) begin
            acm_resetn <= 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          if (bus.TBL_DO) begin
            acm_addr  <= tbl_addr;
            acm_wdata <= bus.TBL_DATA;
            acm_wen   <= 1'b1;
            state     <= WRITE;
          end else begin
            state <= NEXT;
          end
        end
        WRITE: begin
          if (cnt_tc) begin
            acm_wen <= 1'b0;
            if (wr_count != WR_MAX) begin
              wr_count <= wr_count + 1'b1;
            end
            state <= HOLD;
          end
        end
        HOLD: state <= NEXT;
        // Stop on END_A rather than compare against a wrapped address.
        NEXT: begin
          if (tbl_addr == END_A) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            tbl_addr <= tbl_addr + 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.TBL_ADDR  = tbl_addr;
  assign bus.ACMADDR   = acm_addr;
  assign bus.ACMWDATA  = acm_wdata;
  assign bus.ACMWEN    = acm_wen;
  assign bus.ACMRESETN = acm_resetn;
  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.WR_COUNT  = wr_count;

endmodule
